decimator_nch: RTL

//  Parametrised multi-channel sample-rate decimator for the 48 kHz audio path.

---
 rtl/decim_pkg.sv | 24 ++
 rtl/decim_chan.sv | 69 ++++++
 rtl/decimator_nch.sv | 73 +++++++
 3 files changed

// File: rtl/decim_pkg.sv
// Shared helpers for the multi-channel decimator: accumulator sizing, saturation, divide-factor normalisation.
package decim_pkg;

  function automatic int unsigned decim_acc_w(input int unsigned data_w, input int unsigned cnt_w);
    return data_w + cnt_w;
  endfunction

  // Clamp a wide signed value to the signed range of data_w bits.
  function automatic logic signed [63:0] sat_s(input logic signed [63:0] acc,
                                               input int unsigned     data_w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (acc > hi) return hi;
    if (acc < lo) return lo;
    return acc;
  endfunction

  function automatic logic [31:0] neff(input logic [31:0] nfreq);
    return (nfreq == 32'd0) ? 32'd1 : nfreq;
  endfunction

endpackage

// File: rtl/decim_chan.sv
// One decimator channel: optional summing accumulator, saturation and held output register.
// Summing mode is selected with DECIM_SUM_EN; otherwise the channel simply picks the emitted sample.
module decim_chan
  import decim_pkg::*;
#(
  parameter int unsigned DATA_W = 18,
  parameter int unsigned CNT_W  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              emit_i,
  input  logic              acc_en_i,
  input  logic              clr_i,
  input  logic [DATA_W-1:0] din_i,
  output logic [DATA_W-1:0] dout_o,
  output logic              clip_c
);

`ifdef DECIM_SUM_EN
  localparam int unsigned ACC_W = decim_acc_w(DATA_W, CNT_W);

  logic signed [ACC_W-1:0]  acc_q;
  logic signed [ACC_W-1:0]  acc_d;
  logic signed [ACC_W-1:0]  sum_c;
  logic signed [63:0]       sat_c;
  logic        [DATA_W-1:0] dout_d;

  // A resync in the same cycle discards the partial window before adding this sample.
  always_comb begin
    acc_d  = acc_q;
    dout_d = dout_o;
    clip_c = 1'b0;
    sum_c  = (clr_i ? ACC_W'(0) : acc_q) + ACC_W'($signed(din_i));
    sat_c  = sat_s(64'(sum_c), DATA_W);
    if (emit_i) begin
      dout_d = DATA_W'(sat_c);
      acc_d  = '0;
      clip_c = (sat_c != 64'(sum_c));
    end else if (acc_en_i) begin
      acc_d = sum_c;
    end else if (clr_i) begin
      acc_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q  <= '0;
      dout_o <= '0;
    end else begin
      acc_q  <= acc_d;
      dout_o <= dout_d;
    end
  end
`else
  logic unused_c;
  assign unused_c = ^{acc_en_i, clr_i};
  assign clip_c   = 1'b0;

  always_ff @(posedge clock) begin
    if (reset) begin
      dout_o <= '0;
    end else if (emit_i) begin
      dout_o <= din_i;
    end
  end
`endif

endmodule

// File: rtl/decimator_nch.sv
// NCH-channel decimator by nfreq with one shared phase counter and a one-cycle output strobe.
// Define DECIM_SUM_EN to emit the saturated window sum instead of the picked sample.
module decimator_nch
  import decim_pkg::*;
#(
  parameter int unsigned DATA_W = 18,
  parameter int unsigned NCH    = 2,
  parameter int unsigned CNT_W  = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [CNT_W-1:0]      nfreq,
  input  logic                  resync,
  input  logic [NCH*DATA_W-1:0] datain,
  input  logic                  endatain,
  output logic [NCH*DATA_W-1:0] dataout,
  output logic                  endataout,
  output logic                  sat_flag
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             str_d;
  logic             sat_d;
  logic             emit_c;
  logic             acc_en_c;
  logic [NCH-1:0]   clip_c;

  // Divide factor is only looked at on reload, so mid-window changes finish the current countdown.
  always_comb begin
    emit_c   = endatain & (resync | (cnt_q == '0));
    acc_en_c = endatain & ~emit_c;
    cnt_d    = cnt_q;
    str_d    = emit_c;
    sat_d    = sat_flag | (|clip_c);
    if (emit_c) begin
      cnt_d = CNT_W'(neff(32'(nfreq)) - 32'd1);
    end else if (acc_en_c) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else if (resync) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q     <= '0;
      endataout <= 1'b0;
      sat_flag  <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      endataout <= str_d;
      sat_flag  <= sat_d;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    decim_chan #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
    ) u_chan (
      .clock    (clock),
      .reset    (reset),
      .emit_i   (emit_c),
      .acc_en_i (acc_en_c),
      .clr_i    (resync),
      .din_i    (datain[g*DATA_W +: DATA_W]),
      .dout_o   (dataout[g*DATA_W +: DATA_W]),
      .clip_c   (clip_c[g])
    );
  end

endmodule
